shift_add_multiplier_32_bit: RTL and testbench
==============================================

# shift_add_multiplier_32_bit

Iterative 32x32 -> 64-bit multiplier for the ALU, one partial product per clock. It consumes the combinational 32-bit adder (`thirty_two_bit_adder`, ports a, b, c_in -> sum, c_out) as its only add path. It sits beside the adder in the ALU execute stage and presents a start/done handshake to the ALU control. It supports unsigned and two's-complement signed operands with a fixed 34-cycle latency.

## Interface
- No parameters; width fixed at 32-bit operands, 64-bit product.
- clk  in  1  rising-edge clock; only clock in the block.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request; sampled only when busy=0.
- is_signed  in  1  1 = both operands two's complement, 0 = unsigned; latched with start.
- a  in  32  multiplicand; latched with start.
- b  in  32  multiplier; latched with start.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse; product valid.
- product  out  64  result; held until the next accepted start completes.

## Operation
- States: IDLE, RUN, FIX.
- IDLE, start=1:
  - latch mag_a=|a| and mag_b=|b| when is_signed=1, else raw a and b;
  - latch neg = is_signed & (a[31]^b[31]);
  - clear acc_hi[31:0]; acc_lo <= mag_b; count <= 0; go to RUN.
- |x| for x=0x80000000 is 0x80000000, which is representable as unsigned 32-bit. No special case.
- RUN, each cycle:
  - adder inputs a=acc_hi, b=(acc_lo[0] ? mag_a : 0), c_in=0;
  - {acc_hi, acc_lo} <= {c_out, sum, acc_lo[31:1]}, a right shift of the 65-bit {c_out,sum,acc_lo};
  - count++; after the 32nd iteration (count==31) go to FIX.
- FIX, one cycle:
  - product <= neg ? (~{acc_hi,acc_lo} + 1) : {acc_hi,acc_lo};
  - done <= 1; go to IDLE.
  - FIX is taken for unsigned operations too, so latency is constant.
- Truncation: none. The full 64-bit product is always exact in both modes.
- start while busy=1 is ignored. There is no queueing and latched operands are unaffected.
- Operand inputs are don't-care except in the cycle start is accepted.

## Timing
- Reset values: state=IDLE, busy=0, done=0, product=0, internal accumulators and count=0.
- Reset asserted mid-operation aborts immediately. No done pulse is produced for the aborted op, and product returns to 0.
- Latency: start accepted at edge N; done=1 and product valid in the cycle following edge N+33 (34 clocks).
- busy: 1 in the cycles after edges N..N+32 (RUN and FIX); 0 from edge N+33 onward.
- done: high exactly one cycle, the first cycle with busy=0; cleared at the next edge.
- Back-to-back: start=1 during the done cycle is accepted (state is IDLE). The next done follows 34 clocks later. product keeps the previous result until then.
- product changes only at the FIX->IDLE edge or on reset.
- Throughput: one multiply per 34 clocks.

## Test plan
- Unsigned max: is_signed=0, a=b=0xFFFFFFFF -> product=0xFFFFFFFE00000001. done exactly 34 clocks after the start edge, one cycle wide; busy high for 33 cycles.
- Signed extremes:
  - is_signed=1, a=0x80000000 (-2147483648), b=0x7FFFFFFF -> 0xC000000080000000;
  - a=b=0x80000000 -> 0x4000000000000000.
- Mixed sign and mode: is_signed=1, a=-294967, b=67296 -> product = -19850099232 as signed 64-bit. Same bit patterns with is_signed=0 -> unsigned product of 0xFFFB7FC9 x 0x000106E0.
- Handshake:
  - 5x7 -> 35;
  - pulse start with 0x0 x 0x12345678 on cycle 10 of busy -> ignored, result still 35;
  - start asserted during the done cycle with 3x4 -> accepted, product stays 35 until 12 appears 34 clocks later.
- Reset mid-op: start 0xFFFFFFFF x 2, assert rst at clock 15 -> busy=0, done=0, product=0 immediately (asynchronous). After release, no done pulse appears; a fresh 6x7 returns 42.
- Zero and one: 0 x 0xDEADBEEF -> 0; signed 1 x -1 -> 0xFFFFFFFFFFFFFFFF; unsigned 1 x 0xFFFFFFFF -> 0x00000000FFFFFFFF.

Source files
------------

// File: rtl/shift_add_multiplier_32_bit_if.sv
// Start/done handshake between the ALU control (master) and the
// iterative multiplier (slave).
interface shift_add_multiplier_32_bit_if;
  logic        start;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;

  modport master (
    output start, is_signed, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, is_signed, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/shift_add_multiplier_32_bit.sv
// Iterative 32x32 -> 64-bit shift-add multiplier. One partial product per
// clock through a 32-bit adder, with a fixed 34-cycle latency.
// Signed operands are multiplied as magnitudes and the sign is applied
// in a final fix-up cycle.

// Combinational 32-bit adder; the multiplier's only add path.
module thirty_two_bit_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] sum,
  output logic        c_out
);
  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {32'd0, c_in};
endmodule

module shift_add_multiplier_32_bit (
  input  logic                                clk,
  input  logic                                rst,
  shift_add_multiplier_32_bit_if.slave        bus
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state_q;
  logic [31:0] mag_a_q;
  logic [31:0] acc_hi_q;
  logic [31:0] acc_lo_q;
  logic        neg_q;
  logic [4:0]  count_q;
  logic        busy_q;
  logic        done_q;
  logic [63:0] product_q;

  logic [31:0] mag_a_d;
  logic [31:0] mag_b_d;
  logic        neg_d;
  logic [63:0] product_d;
  logic [31:0] add_b;
  logic [31:0] add_sum;
  logic        add_c_out;

  // Operand magnitudes and result sign, captured when start is accepted.
  // |0x80000000| stays 0x80000000, which is the correct unsigned magnitude.
  always_comb begin
    mag_a_d = (bus.is_signed && bus.a[31]) ? (~bus.a + 32'd1) : bus.a;
    mag_b_d = (bus.is_signed && bus.b[31]) ? (~bus.b + 32'd1) : bus.b;
    neg_d   = bus.is_signed & (bus.a[31] ^ bus.b[31]);
  end

  // Partial product: add the multiplicand only when the current multiplier bit is set.
  assign add_b = acc_lo_q[0] ? mag_a_q : 32'd0;

  thirty_two_bit_adder u_adder (
    .a     (acc_hi_q),
    .b     (add_b),
    .c_in  (1'b0),
    .sum   (add_sum),
    .c_out (add_c_out)
  );

  // Final sign application on the 64-bit magnitude.
  assign product_d = neg_q ? (~{acc_hi_q, acc_lo_q} + 64'd1) : {acc_hi_q, acc_lo_q};

  // Control FSM and datapath; all outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mag_a_q   <= 32'd0;
      acc_hi_q  <= 32'd0;
      acc_lo_q  <= 32'd0;
      neg_q     <= 1'b0;
      count_q   <= 5'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= 64'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            mag_a_q  <= mag_a_d;
            acc_hi_q <= 32'd0;
            acc_lo_q <= mag_b_d;
            neg_q    <= neg_d;
            count_q  <= 5'd0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          // 65-bit {carry, sum, acc_lo} shifted right by one; the consumed
          // multiplier bit drops off the bottom.
          {acc_hi_q, acc_lo_q} <= {add_c_out, add_sum, acc_lo_q[31:1]};
          count_q <= count_q + 5'd1;
          if (count_q == 5'd31) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          product_q <= product_d;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
endmodule

// File: tb/tb_shift_add_multiplier_32_bit.sv
// Self-checking bench for shift_add_multiplier_32_bit: directed cases
// from the test plan plus randomized operands against an arithmetic model.
module tb_shift_add_multiplier_32_bit;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  shift_add_multiplier_32_bit_if bus ();

  shift_add_multiplier_32_bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: exact product from plain integer arithmetic.
  function automatic logic [63:0] ref_mul(input logic [31:0] av, input logic [31:0] bv,
                                          input logic s);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    if (s) begin
      sa = {{32{av[31]}}, av};
      sb = {{32{bv[31]}}, bv};
      return 64'(sa * sb);
    end
    return {32'd0, av} * {32'd0, bv};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Present one request; returns at #1 after the accepting edge.
  task automatic start_op(input logic [31:0] av, input logic [31:0] bv, input logic s);
    bus.a         = av;
    bus.b         = bv;
    bus.is_signed = s;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.a         = $urandom;
    bus.b         = $urandom;
    bus.is_signed = 1'($urandom_range(0, 1));
  endtask

  // Wait for done, counting clocks since acceptance and busy cycles; product
  // must hold its old value until done. Optionally pulses a start mid-op.
  task automatic wait_done(input logic [63:0] hold, input int pulse_at,
                           output int lat, output int busy_n);
    logic hold_ok;
    hold_ok = 1'b1;
    lat     = 1;
    busy_n  = bus.busy ? 1 : 0;
    while (!bus.done && lat < 100) begin
      if (pulse_at == lat) begin
        bus.start = 1'b1;
        bus.a     = 32'h0;
        bus.b     = 32'h12345678;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat++;
      if (bus.busy) busy_n++;
      if (!bus.done && bus.product !== hold) hold_ok = 1'b0;
    end
    check("product_hold", {63'd0, hold_ok}, 64'd1);
  endtask

  // Full transaction; returns during the done cycle.
  task automatic mul_check(input string tag, input logic [31:0] av, input logic [31:0] bv,
                           input logic s, input int pulse_at, input logic [63:0] exp);
    int lat;
    int busy_n;
    logic [63:0] hold;
    hold = bus.product;
    start_op(av, bv, s);
    wait_done(hold, pulse_at, lat, busy_n);
    check({tag, "_lat"}, 64'(lat), 64'd34);
    check({tag, "_busy"}, 64'(busy_n), 64'd33);
    check(tag, bus.product, exp);
    $display("op %s a=%h b=%h signed=%0d product=%h lat=%0d", tag, av, bv, s, bus.product, lat);
  endtask

  task automatic idle_step();
    @(posedge clk);
    #1;
    check("done_width", {63'd0, bus.done}, 64'd0);
    check("busy_idle", {63'd0, bus.busy}, 64'd0);
  endtask

  initial begin
    int dones;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.a         = 32'd0;
    bus.b         = 32'd0;

    #12;
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_product", bus.product, 64'd0);
    #10 rst = 1'b0;
    @(posedge clk);
    #1;

    // Unsigned maximum
    mul_check("umax", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0, 64'hFFFFFFFE00000001);
    idle_step();

    // Signed extremes
    mul_check("smin_x_smax", 32'h80000000, 32'h7FFFFFFF, 1'b1, 0, 64'hC000000080000000);
    idle_step();
    mul_check("smin_x_smin", 32'h80000000, 32'h80000000, 1'b1, 0, 64'h4000000000000000);
    idle_step();

    // Mixed sign, same bit patterns in both modes
    mul_check("mixed_s", 32'hFFFB7FC9, 32'h000106E0, 1'b1, 0, -64'sd19850099232);
    idle_step();
    mul_check("mixed_u", 32'hFFFB7FC9, 32'h000106E0, 1'b0, 0,
              ref_mul(32'hFFFB7FC9, 32'h000106E0, 1'b0));
    idle_step();

    // Handshake: start during busy ignored, start during done accepted
    mul_check("hs_5x7", 32'd5, 32'd7, 1'b0, 10, 64'd35);
    mul_check("hs_b2b_3x4", 32'd3, 32'd4, 1'b0, 0, 64'd12);
    idle_step();

    // Zero and one
    mul_check("zero", 32'd0, 32'hDEADBEEF, 1'b0, 0, 64'd0);
    idle_step();
    mul_check("s1_x_m1", 32'd1, 32'hFFFFFFFF, 1'b1, 0, 64'hFFFFFFFFFFFFFFFF);
    idle_step();
    mul_check("u1_x_max", 32'd1, 32'hFFFFFFFF, 1'b0, 0, 64'h00000000FFFFFFFF);
    idle_step();

    // Asynchronous reset in the middle of an operation
    start_op(32'hFFFFFFFF, 32'd2, 1'b0);
    repeat (14) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_busy", {63'd0, bus.busy}, 64'd0);
    check("arst_done", {63'd0, bus.done}, 64'd0);
    check("arst_product", bus.product, 64'd0);
    $display("op reset_mid_op busy=%0d done=%0d product=%h", bus.busy, bus.done, bus.product);
    #10 rst = 1'b0;
    @(posedge clk);
    #1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) dones++;
      @(posedge clk);
      #1;
    end
    check("arst_no_done", 64'(dones), 64'd0);
    mul_check("post_rst_6x7", 32'd6, 32'd7, 1'b0, 0, 64'd42);
    idle_step();

    // Randomized operands, mixing back-to-back and idle gaps
    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 3))
        0: ra = 32'h80000000;
        1: ra = 32'hFFFFFFFF;
        default: ra = $urandom;
      endcase
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      mul_check("rand", ra, rb, rs, 0, ref_mul(ra, rb, rs));
      if ($urandom_range(0, 1) == 1) idle_step();
    end
    idle_step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
